// File: rtl/Modules_pkg.sv
// Shared execute-stage types: operand width, functional-unit state and divider enums.
package Modules_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIVIDE   = 2'd1,
        FINALIZE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per enabled clock.
module div_unit
    import Modules_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output fu_state_e       fu_state_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    div_ops_e        op_q, op_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    logic            in_signed;
    logic            in_dz;
    logic            in_ovf;
    logic [XLEN-1:0] shifted;
    logic [XLEN:0]   trial;
    logic            quo_bit;
    logic            is_div;
    logic [XLEN-1:0] quo_res;
    logic [XLEN-1:0] rem_res;

    always_comb begin
        in_signed = (operation_i == DIV_) || (operation_i == REM_);
        in_dz     = (divisor_i == '0);
        in_ovf    = in_signed && (dividend_i == IntMin) && (divisor_i == '1);

        // rem stays below 2^(XLEN-1) before the shift, so dropping its MSB loses nothing.
        shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        trial   = {1'b0, shifted} - {1'b0, dvsr_q};
        quo_bit = ~trial[XLEN];

        is_div  = (op_q == DIV_) || (op_q == DIVU_);
        quo_res = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        rem_res = neg_r_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d    = operation_i;
                    neg_q_d = in_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                    neg_r_d = in_signed & dividend_i[XLEN-1];
                    dvsr_d  = in_signed ? abs_val(divisor_i) : divisor_i;
                    dz_d    = in_dz;
                    ovf_d   = in_ovf;
                    rem_d   = '0;
                    if (in_dz || in_ovf) begin
                        // Raw dividend kept for REM by zero.
                        quo_d   = dividend_i;
                        state_d = FINALIZE;
                    end else begin
                        quo_d   = in_signed ? abs_val(dividend_i) : dividend_i;
                        cnt_d   = CntW'(XLEN - 1);
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = quo_bit ? trial[XLEN-1:0] : shifted;
                quo_d = {quo_q[XLEN-2:0], quo_bit};
                if (cnt_q == '0) begin
                    state_d = FINALIZE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINALIZE: begin
                if (dz_q) begin
                    result_d = is_div ? '1 : quo_q;
                end else if (ovf_q) begin
                    result_d = is_div ? IntMin : '0;
                end else begin
                    result_d = is_div ? quo_res : rem_res;
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= DIV_;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            op_q     <= op_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign fu_state_o     = (state_q == IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
    import Modules_pkg::*;

    logic            clk_i;
    logic            rst_i;
    logic            clk_en_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    div_ops_e        operation_i;
    logic            valid_i;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    fu_state_e       fu_state_o;

    int n_checks;
    int n_fails;

    div_unit u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clk_en_i       (clk_en_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .operation_i    (operation_i),
        .valid_i        (valid_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .fu_state_o     (fu_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit is_special(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (op == DIV_) || (op == REM_);
        return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics written directly from the ISA rules.
    function automatic logic [31:0] model(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        if (b == 0) return (op == DIV_ || op == DIVU_) ? 32'hFFFF_FFFF : a;
        if ((op == DIV_ || op == REM_) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == DIV_) ? 32'h8000_0000 : 32'h0;
        case (op)
            DIV_:    return sa / sb;
            DIVU_:   return a / b;
            REM_:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic issue(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        operation_i = op;
        dividend_i  = a;
        divisor_i   = b;
        valid_i     = 1'b1;
        tick();
        valid_i     = 1'b0;
        dividend_i  = $urandom;
        divisor_i   = $urandom;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid_o && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("result_valid seen", {31'b0, result_valid_o}, 32'd1);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp);
        check_eq({tag, " result"}, result_o, exp);
        tick();
        check_eq({tag, " valid drop"}, {31'b0, result_valid_o}, 32'd0);
        check_eq({tag, " result hold"}, result_o, exp);
        check_eq({tag, " free"}, {31'b0, fu_state_o}, {31'b0, FREE});
    endtask

    task automatic run_op(input string tag, input div_ops_e op, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        logic [31:0] exp = model(op, a, b);
        issue(op, a, b);
        check_eq({tag, " busy"}, {31'b0, fu_state_o}, {31'b0, BUSY});
        wait_result(lat);
        check_eq({tag, " latency"}, lat, is_special(op, a, b) ? 32'd1 : 32'd33);
        finish_op(tag, exp);
    endtask

    initial begin
        int lat;
        int lat2;
        int pulses;
        logic [31:0] snap;

        n_checks    = 0;
        n_fails     = 0;
        rst_i       = 1'b1;
        clk_en_i    = 1'b1;
        valid_i     = 1'b0;
        dividend_i  = '0;
        divisor_i   = '0;
        operation_i = DIV_;
        tick();
        tick();
        rst_i = 1'b0;
        check_eq("reset result", result_o, 32'd0);
        check_eq("reset valid", {31'b0, result_valid_o}, 32'd0);
        check_eq("reset state", {31'b0, fu_state_o}, {31'b0, FREE});

        run_op("divu 100/7", DIVU_, 32'd100, 32'd7);
        run_op("remu 100/7", REMU_, 32'd100, 32'd7);
        run_op("div -7/2", DIV_, 32'hFFFF_FFF9, 32'd2);
        run_op("rem -7/2", REM_, 32'hFFFF_FFF9, 32'd2);
        run_op("divu big/2", DIVU_, 32'hFFFF_FFF9, 32'd2);
        run_op("div 5/0", DIV_, 32'd5, 32'd0);
        run_op("remu 5/0", REMU_, 32'd5, 32'd0);
        run_op("div ovf", DIV_, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem ovf", REM_, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu min/-1", DIVU_, 32'h8000_0000, 32'hFFFF_FFFF);

        // Stall for 5 cycles mid-iteration; outputs must hold.
        issue(DIVU_, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        clk_en_i = 1'b0;
        snap = result_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall result", result_o, snap);
            check_eq("stall valid", {31'b0, result_valid_o}, 32'd0);
            check_eq("stall busy", {31'b0, fu_state_o}, {31'b0, BUSY});
        end
        clk_en_i = 1'b1;
        wait_result(lat);
        check_eq("stall latency", lat + 10, 32'd38);
        finish_op("stall", 32'd14);

        // Reset mid-operation aborts without a pulse.
        issue(DIVU_, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("abort free", {31'b0, fu_state_o}, {31'b0, FREE});
        check_eq("abort result", result_o, 32'd0);
        check_eq("abort valid", {31'b0, result_valid_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid_o) pulses++;
        end
        check_eq("abort pulses", pulses, 32'd0);
        run_op("divu 9/3", DIVU_, 32'd9, 32'd3);

        // Requests while busy are dropped; one in the result cycle is accepted.
        issue(DIVU_, 32'd100, 32'd10);
        for (int i = 0; i < 3; i++) tick();
        operation_i = DIVU_;
        dividend_i  = 32'd1;
        divisor_i   = 32'd1;
        valid_i     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        valid_i = 1'b0;
        wait_result(lat);
        check_eq("busy latency", lat + 8, 32'd33);
        check_eq("busy result", result_o, 32'd10);
        issue(DIVU_, 32'd1000, 32'd7);
        check_eq("b2b busy", {31'b0, fu_state_o}, {31'b0, BUSY});
        check_eq("b2b valid drop", {31'b0, result_valid_o}, 32'd0);
        wait_result(lat2);
        check_eq("b2b latency", lat2, 32'd33);
        finish_op("b2b", 32'd142);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid_o) pulses++;
        end
        check_eq("no queued op", pulses, 32'd0);

        for (int n = 0; n < 40; n++) begin
            div_ops_e    op = div_ops_e'($urandom_range(0, 3));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 20);
                3:       b = -$urandom_range(1, 20);
                default: ;
            endcase
            run_op("random", op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
